// File: rtl/regfile_param.sv
// Parametrised multi-port register file with a post-reset clear sweep,
// an optional hardwired zero register and optional write-to-read bypass.
module regfile_param #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NREAD*ADDR_WIDTH-1:0]   ReadRegister,
    output logic [NREAD*WIDTH-1:0]        ReadData,
    input  logic [ADDR_WIDTH-1:0]         WriteRegister,
    input  logic [WIDTH-1:0]              WriteData,
    input  logic                          RegWrite,
    output logic                          Ready,
    output logic                          WriteDropped
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clear_ptr_q, clear_ptr_d;
    logic                   ready_q, ready_d;
    logic                   write_dropped_q, write_dropped_d;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;
    logic                   write_to_zero;
    logic                   write_ok;

    always_comb begin
        write_to_zero   = (ZERO_REG != 0) && (WriteRegister == '0);
        write_ok        = RegWrite && ready_q && !write_to_zero;
        state_d         = state_q;
        clear_ptr_d     = clear_ptr_q;
        ready_d         = ready_q;
        write_dropped_d = RegWrite && !ready_q;

        // The pointer parks on the last entry instead of wrapping.
        if (state_q == CLEAR) begin
            if (clear_ptr_q == LAST_ADDR) begin
                state_d = READY;
                ready_d = 1'b1;
            end else begin
                clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = WriteRegister;
        mem_wdata = WriteData;
        if (Reset) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            mem_wdata = '0;
        end else if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_ptr_q;
            mem_wdata = '0;
        end else if (write_ok) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= CLEAR;
            clear_ptr_q     <= '0;
            ready_q         <= 1'b0;
            write_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_ptr_q     <= clear_ptr_d;
            ready_q         <= ready_d;
            write_dropped_q <= write_dropped_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Reads are forced to zero until the sweep has finished.
    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] raddr;
        logic                  is_zero;
        logic                  hit;

        assign raddr   = ReadRegister[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (raddr == '0);
        assign hit     = (BYPASS != 0) && RegWrite && ready_q &&
                         (WriteRegister == raddr) && !is_zero;
        assign ReadData[k*WIDTH +: WIDTH] = (!ready_q || is_zero) ? '0 :
                                            hit ? WriteData : mem_q[raddr];
    end

    assign Ready        = ready_q;
    assign WriteDropped = write_dropped_q;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param: three configurations
// (default, 4-port bypass, 8x8 without zero register) against array models.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: defaults
    logic         rst_a, we_a, ready_a, drop_a;
    logic [9:0]   rr_a;
    logic [63:0]  rd_a;
    logic [4:0]   wr_a;
    logic [31:0]  wd_a;

    // Instance B: NREAD=4, BYPASS=1, ZERO_REG=1
    logic         rst_b, we_b, ready_b, drop_b;
    logic [19:0]  rr_b;
    logic [127:0] rd_b;
    logic [4:0]   wr_b;
    logic [31:0]  wd_b;

    // Instance C: WIDTH=8, ADDR_WIDTH=3, ZERO_REG=0
    logic         rst_c, we_c, ready_c, drop_c;
    logic [5:0]   rr_c;
    logic [15:0]  rd_c;
    logic [2:0]   wr_c;
    logic [7:0]   wd_c;

    regfile_param dut_a (
        .Clk(clk), .Reset(rst_a), .ReadRegister(rr_a), .ReadData(rd_a),
        .WriteRegister(wr_a), .WriteData(wd_a), .RegWrite(we_a),
        .Ready(ready_a), .WriteDropped(drop_a)
    );

    regfile_param #(.WIDTH(32), .ADDR_WIDTH(5), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .Clk(clk), .Reset(rst_b), .ReadRegister(rr_b), .ReadData(rd_b),
        .WriteRegister(wr_b), .WriteData(wd_b), .RegWrite(we_b),
        .Ready(ready_b), .WriteDropped(drop_b)
    );

    regfile_param #(.WIDTH(8), .ADDR_WIDTH(3), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_c (
        .Clk(clk), .Reset(rst_c), .ReadRegister(rr_c), .ReadData(rd_c),
        .WriteRegister(wr_c), .WriteData(wd_c), .RegWrite(we_c),
        .Ready(ready_c), .WriteDropped(drop_c)
    );

    // Reference models: contents, edges since reset, ready and dropped flags
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [7:0]  mem_c [8];
    int cnt_a, cnt_b, cnt_c;
    bit rdy_a, rdy_b, rdy_c;
    bit drp_a, drp_b, drp_c;

    // Advance one clock edge; each model updates from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_a) begin
            cnt_a = 0; rdy_a = 0; drp_a = 0;
            foreach (mem_a[i]) mem_a[i] = '0;
        end else begin
            drp_a = we_a && !rdy_a;
            if (rdy_a && we_a && wr_a != 0) mem_a[wr_a] = wd_a;
            if (!rdy_a) begin cnt_a++; rdy_a = (cnt_a == 32); end
        end
        if (rst_b) begin
            cnt_b = 0; rdy_b = 0; drp_b = 0;
            foreach (mem_b[i]) mem_b[i] = '0;
        end else begin
            drp_b = we_b && !rdy_b;
            if (rdy_b && we_b && wr_b != 0) mem_b[wr_b] = wd_b;
            if (!rdy_b) begin cnt_b++; rdy_b = (cnt_b == 32); end
        end
        if (rst_c) begin
            cnt_c = 0; rdy_c = 0; drp_c = 0;
            foreach (mem_c[i]) mem_c[i] = '0;
        end else begin
            drp_c = we_c && !rdy_c;
            if (rdy_c && we_c) mem_c[wr_c] = wd_c;
            if (!rdy_c) begin cnt_c++; rdy_c = (cnt_c == 8); end
        end
        #1;
    endtask

    function automatic logic [31:0] exp_a(input logic [4:0] ad);
        return (!rdy_a || ad == 0) ? 32'h0 : mem_a[ad];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] ad);
        if (!rdy_b || ad == 0) return 32'h0;
        if (we_b && wr_b == ad) return wd_b;
        return mem_b[ad];
    endfunction

    function automatic logic [7:0] exp_c(input logic [2:0] ad);
        return rdy_c ? mem_c[ad] : 8'h0;
    endfunction

    task automatic test_reset();
        rst_a = 1; rst_b = 1; rst_c = 1;
        we_a = 0; we_b = 0; we_c = 0;
        tick();
        tick();
        rr_a = {5'd7, 5'd3};
        #1;
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready_a); end
        total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL reset_read: got %h expected 0", rd_a); end
        total++; if (drop_a !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b expected 0", drop_a); end
        rst_a = 0; rst_b = 0; rst_c = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            rr_a = 10'($urandom);
            #1;
            total++; if (ready_a !== 1'(i >= 32)) begin bad++; $display("FAIL sweep_ready_a edge %0d: got %b expected %b", i, ready_a, i >= 32); end
            total++; if (ready_c !== 1'(i >= 8)) begin bad++; $display("FAIL sweep_ready_c edge %0d: got %b expected %b", i, ready_c, i >= 8); end
            total++; if (drop_a !== 1'b0) begin bad++; $display("FAIL sweep_drop edge %0d: got %b expected 0", i, drop_a); end
            if (i < 32) begin
                total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL sweep_read edge %0d: got %h expected 0", i, rd_a); end
            end
        end
        for (int ad = 0; ad < 32; ad++) begin
            rr_a = {5'(ad), 5'(31 - ad)};
            #1;
            total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL cleared_read r%0d: got %h expected 0", ad, rd_a); end
        end
    endtask

    task automatic test_write_read();
        we_a = 1; wr_a = 5'd2; wd_a = 32'd42;
        tick();
        we_a = 0; rr_a = {5'd2, 5'd2};
        #1;
        total++; if (rd_a !== {32'd42, 32'd42}) begin bad++; $display("FAIL write42: got %h expected %h", rd_a, {32'd42, 32'd42}); end
        we_a = 1; wd_a = 32'd15;
        tick();
        we_a = 0;
        #1;
        total++; if (rd_a !== {32'd15, 32'd15}) begin bad++; $display("FAIL write15: got %h expected %h", rd_a, {32'd15, 32'd15}); end
        rr_a = {5'd3, 5'd3};
        #1;
        total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL read_r3: got %h expected 0", rd_a); end
    endtask

    task automatic test_zero_reg();
        we_a = 1; wr_a = 5'd0; wd_a = 32'hDEADBEEF; rr_a = {5'd0, 5'd0};
        we_c = 1; wr_c = 3'd0; wd_c = 8'hEF;      rr_c = {3'd0, 3'd0};
        tick();
        we_a = 0; we_c = 0;
        #1;
        total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL zero_reg_read: got %h expected 0", rd_a); end
        total++; if (drop_a !== 1'b0) begin bad++; $display("FAIL zero_reg_drop: got %b expected 0", drop_a); end
        total++; if (rd_c !== 16'hEFEF) begin bad++; $display("FAIL nonzero_r0_read: got %h expected efef", rd_c); end
    endtask

    task automatic test_bypass();
        we_a = 1; wr_a = 5'd9; wd_a = 32'd3;
        we_b = 1; wr_b = 5'd9; wd_b = 32'd3;
        tick();
        wd_a = 32'd99; wd_b = 32'd99;
        rr_a = {5'd9, 5'd9};
        rr_b = {5'd0, 5'd1, 5'd9, 5'd9};
        #1;
        total++; if (rd_b !== {32'd0, 32'd0, 32'd99, 32'd99}) begin bad++; $display("FAIL bypass_pre: got %h expected %h", rd_b, {32'd0, 32'd0, 32'd99, 32'd99}); end
        total++; if (rd_a !== {32'd3, 32'd3}) begin bad++; $display("FAIL nobypass_pre: got %h expected %h", rd_a, {32'd3, 32'd3}); end
        tick();
        we_a = 0; we_b = 0;
        #1;
        total++; if (rd_b[63:0] !== {32'd99, 32'd99}) begin bad++; $display("FAIL bypass_post: got %h expected %h", rd_b[63:0], {32'd99, 32'd99}); end
        total++; if (rd_a !== {32'd99, 32'd99}) begin bad++; $display("FAIL nobypass_post: got %h expected %h", rd_a, {32'd99, 32'd99}); end
    endtask

    task automatic test_small();
        we_c = 1; wr_c = 3'd7; wd_c = 8'hA5;
        tick();
        wr_c = 3'd1; wd_c = 8'h5A;
        tick();
        we_c = 0; rr_c = {3'd1, 3'd7};
        #1;
        total++; if (rd_c !== 16'h5AA5) begin bad++; $display("FAIL small_read: got %h expected 5aa5", rd_c); end
    endtask

    task automatic test_reset_mid_sweep();
        we_a = 1; wr_a = 5'd5; wd_a = 32'd7;
        tick();
        we_a = 0; rr_a = {5'd5, 5'd5};
        #1;
        total++; if (rd_a !== {32'd7, 32'd7}) begin bad++; $display("FAIL r5_before: got %h expected %h", rd_a, {32'd7, 32'd7}); end
        rst_a = 1;
        tick();
        rst_a = 0;
        for (int i = 1; i <= 10; i++) begin
            we_a = (i % 3 == 1);
            tick();
            total++; if (drop_a !== drp_a) begin bad++; $display("FAIL drop_sweep edge %0d: got %b expected %b", i, drop_a, drp_a); end
            total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL ready_sweep edge %0d: got %b expected 0", i, ready_a); end
        end
        rst_a = 1; we_a = 1;
        tick();
        total++; if (drop_a !== 1'b0) begin bad++; $display("FAIL drop_in_reset: got %b expected 0", drop_a); end
        rst_a = 0;
        for (int i = 1; i <= 32; i++) begin
            we_a = (i == 5);
            tick();
            total++; if (ready_a !== 1'(i == 32)) begin bad++; $display("FAIL restart_ready edge %0d: got %b expected %b", i, ready_a, i == 32); end
            total++; if (drop_a !== drp_a) begin bad++; $display("FAIL restart_drop edge %0d: got %b expected %b", i, drop_a, drp_a); end
        end
        we_a = 0; rr_a = {5'd5, 5'd5};
        #1;
        total++; if (rd_a !== 64'h0) begin bad++; $display("FAIL r5_after: got %h expected 0", rd_a); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_a = ($urandom_range(0, 149) == 0);
            rst_b = ($urandom_range(0, 149) == 0);
            rst_c = ($urandom_range(0, 149) == 0);
            we_a = 1'($urandom); wr_a = 5'($urandom_range(0, 7)); wd_a = $urandom;
            we_b = 1'($urandom); wr_b = 5'($urandom_range(0, 7)); wd_b = $urandom;
            we_c = 1'($urandom); wr_c = 3'($urandom);             wd_c = 8'($urandom);
            for (int k = 0; k < 2; k++) rr_a[k*5 +: 5] = 5'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++) rr_b[k*5 +: 5] = 5'($urandom_range(0, 7));
            rr_c = 6'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd_a[k*32 +: 32] !== exp_a(rr_a[k*5 +: 5])) begin
                    bad++; $display("FAIL rand_read_a cyc %0d port %0d: got %h expected %h", n, k, rd_a[k*32 +: 32], exp_a(rr_a[k*5 +: 5]));
                end
            end
            for (int k = 0; k < 4; k++) begin
                total++;
                if (rd_b[k*32 +: 32] !== exp_b(rr_b[k*5 +: 5])) begin
                    bad++; $display("FAIL rand_read_b cyc %0d port %0d: got %h expected %h", n, k, rd_b[k*32 +: 32], exp_b(rr_b[k*5 +: 5]));
                end
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (rd_c[k*8 +: 8] !== exp_c(rr_c[k*3 +: 3])) begin
                    bad++; $display("FAIL rand_read_c cyc %0d port %0d: got %h expected %h", n, k, rd_c[k*8 +: 8], exp_c(rr_c[k*3 +: 3]));
                end
            end
            tick();
            total++; if (ready_a !== rdy_a || ready_b !== rdy_b || ready_c !== rdy_c) begin bad++; $display("FAIL rand_ready cyc %0d: got %b%b%b expected %b%b%b", n, ready_a, ready_b, ready_c, rdy_a, rdy_b, rdy_c); end
            total++; if (drop_a !== drp_a || drop_b !== drp_b || drop_c !== drp_c) begin bad++; $display("FAIL rand_drop cyc %0d: got %b%b%b expected %b%b%b", n, drop_a, drop_b, drop_c, drp_a, drp_b, drp_c); end
        end
    endtask

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        we_a = 0; we_b = 0; we_c = 0;
        rr_a = '0; rr_b = '0; rr_c = '0;
        wr_a = '0; wr_b = '0; wr_c = '0;
        wd_a = '0; wd_b = '0; wd_c = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_small();
        test_reset_mid_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
